// File: rtl/itch_inst_decoder.sv
// itch_inst_decoder: framed ITCH 5.0 byte stream to order-map instructions
package pipebomb_pkg;
  localparam int ORDER_ID_BITS = 32;
  localparam int QTY_BITS = 32;
  localparam int PRICE_BITS = 32;
  typedef enum logic [2:0] {ITCH_NOP, ITCH_ADD, ITCH_EXECUTE, ITCH_CANCEL, ITCH_DELETE} itch_op_e;
  typedef struct packed {
    logic                     valid;
    itch_op_e                 op;
    logic [ORDER_ID_BITS-1:0] order_id;
    logic                     side;
    logic [QTY_BITS-1:0]      qty;
    logic [PRICE_BITS-1:0]    price;
  } inst_t;
endpackage

module itch_inst_decoder
  import pipebomb_pkg::*;
#(
  parameter int STAT_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_v,
  output logic                 in_r,
  input  logic [7:0]           in_data,
  input  logic                 in_last,
  output logic                 out_v,
  input  logic                 out_r,
  output inst_t                out_d,
  output logic                 err_pulse,
  output logic [STAT_BITS-1:0] msg_cnt,
  output logic [STAT_BITS-1:0] drop_cnt
);
  localparam logic [1:0] IDLE = 2'd0, BODY = 2'd1, DRAIN = 2'd2, EMIT = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [5:0]           off_q, off_d, len_q, len_d;
  logic [7:0]           typ_q, typ_d;
  logic [63:0]          ref_q, ref_d;
  logic                 side_q, side_d;
  logic [31:0]          qty_q, qty_d, price_q, price_d;
  logic                 err_q, err_d;
  logic [STAT_BITS-1:0] msg_q, msg_d, drop_q, drop_d;
  logic                 fire, is_af, is_ecx, len_err;
  logic [5:0]           in_len;

  assign in_r      = state_q != EMIT;
  assign out_v     = state_q == EMIT;
  assign fire      = in_v && in_r;
  assign err_pulse = err_q;
  assign msg_cnt   = msg_q;
  assign drop_cnt  = drop_q;
  assign is_af     = typ_q == "A" || typ_q == "F";
  assign is_ecx    = typ_q == "E" || typ_q == "C" || typ_q == "X";
  assign in_len    = in_data == "A" ? 6'd36 : in_data == "F" ? 6'd40 : in_data == "E" ? 6'd31 :
                     in_data == "C" ? 6'd36 : in_data == "X" ? 6'd23 : in_data == "D" ? 6'd19 : 6'd0;
  assign len_err   = in_last ^ (off_q == len_q - 6'd1);

  // Frame walker: type byte selects length, body bytes land in fields by offset
  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    len_d   = len_q;
    typ_d   = typ_q;
    ref_d   = ref_q;
    side_d  = side_q;
    qty_d   = qty_q;
    price_d = price_q;
    err_d   = 1'b0;
    msg_d   = msg_q;
    drop_d  = drop_q;
    case (state_q)
      IDLE: if (fire) begin
        typ_d   = in_data;
        len_d   = in_len;
        off_d   = 6'd1;
        ref_d   = '0;
        side_d  = 1'b0;
        qty_d   = '0;
        price_d = '0;
        err_d   = in_len != 6'd0 && in_last;
        drop_d  = (in_len == 6'd0 || in_last) ? drop_q + STAT_BITS'(1) : drop_q;
        state_d = in_last ? IDLE : in_len != 6'd0 ? BODY : DRAIN;
      end
      BODY: if (fire) begin
        off_d   = off_q + 6'd1;
        ref_d   = (off_q >= 6'd11 && off_q <= 6'd18) ? {ref_q[55:0], in_data} : ref_q;
        side_d  = (is_af && off_q == 6'd19) ? in_data == "S" : side_q;
        qty_d   = ((is_af && off_q >= 6'd20 && off_q <= 6'd23) || (is_ecx && off_q >= 6'd19 && off_q <= 6'd22)) ?
                  {qty_q[23:0], in_data} : qty_q;
        price_d = (is_af && off_q >= 6'd32 && off_q <= 6'd35) ? {price_q[23:0], in_data} : price_q;
        err_d   = len_err;
        drop_d  = len_err ? drop_q + STAT_BITS'(1) : drop_q;
        state_d = off_q == len_q - 6'd1 ? (in_last ? EMIT : DRAIN) : in_last ? IDLE : BODY;
      end
      DRAIN: state_d = (fire && in_last) ? IDLE : DRAIN;
      default: begin
        state_d = out_r ? IDLE : EMIT;
        msg_d   = out_r ? msg_q + STAT_BITS'(1) : msg_q;
      end
    endcase
  end

  // Instruction is a pure view of the captured fields, zero outside EMIT
  always_comb begin
    out_d = '0;
    if (state_q == EMIT) begin
      out_d.valid    = 1'b1;
      out_d.op       = is_af ? ITCH_ADD : (typ_q == "E" || typ_q == "C") ? ITCH_EXECUTE :
                       typ_q == "X" ? ITCH_CANCEL : ITCH_DELETE;
      out_d.order_id = ref_q[ORDER_ID_BITS-1:0];
      out_d.side     = side_q;
      out_d.qty      = qty_q[QTY_BITS-1:0];
      out_d.price    = price_q[PRICE_BITS-1:0];
    end
  end

  // State and field registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      off_q   <= '0;
      len_q   <= '0;
      typ_q   <= '0;
      ref_q   <= '0;
      side_q  <= 1'b0;
      qty_q   <= '0;
      price_q <= '0;
      err_q   <= 1'b0;
      msg_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      len_q   <= len_d;
      typ_q   <= typ_d;
      ref_q   <= ref_d;
      side_q  <= side_d;
      qty_q   <= qty_d;
      price_q <= price_d;
      err_q   <= err_d;
      msg_q   <= msg_d;
      drop_q  <= drop_d;
    end
  end
endmodule

// File: tb/tb_itch_inst_decoder.sv
// tb_itch_inst_decoder: scoreboard bench for the ITCH instruction decoder
module tb_itch_inst_decoder;
  import pipebomb_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_v = 1'b0;
  logic        in_r;
  logic [7:0]  in_data = '0;
  logic        in_last = 1'b0;
  logic        out_v;
  logic        out_r = 1'b1;
  inst_t       out_d;
  logic        err_pulse;
  logic [31:0] msg_cnt, drop_cnt;

  itch_inst_decoder #(.STAT_BITS(32)) dut (
    .clk(clk), .rstn(rstn), .in_v(in_v), .in_r(in_r), .in_data(in_data), .in_last(in_last),
    .out_v(out_v), .out_r(out_r), .out_d(out_d), .err_pulse(err_pulse),
    .msg_cnt(msg_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int    chk_cnt = 0, pass_cnt = 0, err_seen = 0, cyc = 0, hs_cyc = 0, acc_cyc = 0, first_acc = 0;
  inst_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: pops the scoreboard on every output handshake
  always @(negedge clk) begin
    if (rstn && err_pulse) err_seen++;
    if (rstn && out_v && out_r) begin
      hs_cyc = cyc;
      chk_cnt++;
      if (exp_q.size() == 0) $display("FAIL unexpected_out: got 0x%0h expected none", out_d);
      else begin
        inst_t e;
        e = exp_q.pop_front();
        if (out_d === e) pass_cnt++;
        else $display("FAIL out_d: got 0x%0h expected 0x%0h", out_d, e);
      end
    end
  end

  function automatic inst_t mk(input itch_op_e op, input logic [63:0] rf, input logic sd,
                               input logic [31:0] qt, input logic [31:0] pr);
    inst_t r;
    r = '0;
    r.valid = 1'b1;
    r.op = op;
    r.order_id = rf[31:0];
    r.side = sd;
    r.qty = qt;
    r.price = pr;
    return r;
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic last);
    int n = 0;
    in_v = 1'b1;
    in_data = b;
    in_last = last;
    while (!in_r && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_r) chk("in_r_timeout", {63'd0, in_r}, 64'd1);
    acc_cyc = cyc;
    @(posedge clk); #1;
    in_v = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic send_msg(input logic [7:0] t, input int n, input logic [63:0] rf, input logic [7:0] sd,
                          input logic [31:0] qt, input logic [31:0] pr, input logic last_en);
    logic af, ecx;
    logic [7:0] b;
    af = t == "A" || t == "F";
    ecx = t == "E" || t == "C" || t == "X";
    for (int i = 0; i < n; i++) begin
      b = i[7:0];
      if (i == 0) b = t;
      if (i >= 11 && i <= 18) b = rf[8*(18-i) +: 8];
      if (af && i == 19) b = sd;
      if (af && i >= 20 && i <= 23) b = qt[8*(23-i) +: 8];
      if (af && i >= 32 && i <= 35) b = pr[8*(35-i) +: 8];
      if (ecx && i >= 19 && i <= 22) b = qt[8*(22-i) +: 8];
      send_byte(b, last_en && i == n - 1);
      if (i == 0) first_acc = acc_cyc;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    inst_t snap;
    logic  stable;
    int    n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_v", {63'd0, out_v}, 64'd0);
    chk("rst_in_r", {63'd0, in_r}, 64'd1);
    chk("rst_out_d", 64'(out_d != '0), 64'd0);
    chk("rst_msg", 64'(msg_cnt), 64'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    exp_q.push_back(mk(ITCH_ADD, 64'h1122_3344_0000_1234, 1'b1, 32'd100, 32'h0001_86A0));
    send_msg("A", 36, 64'h1122_3344_0000_1234, "S", 32'd100, 32'h0001_86A0, 1'b1);
    wait_idle();
    chk("t1_msg", 64'(msg_cnt), 64'd1);

    exp_q.push_back(mk(ITCH_DELETE, 64'h0000_0000_DEAD_BEEF, 1'b0, 32'd0, 32'd0));
    exp_q.push_back(mk(ITCH_CANCEL, 64'h0000_0000_0000_0777, 1'b0, 32'd5, 32'd0));
    send_msg("D", 19, 64'h0000_0000_DEAD_BEEF, 8'h00, 32'd0, 32'd0, 1'b1);
    send_msg("X", 23, 64'h0000_0000_0000_0777, 8'h00, 32'd5, 32'd0, 1'b1);
    chk("t2_x_after_hs", 64'(first_acc), 64'(hs_cyc + 1));
    wait_idle();
    chk("t2_msg", 64'(msg_cnt), 64'd3);

    send_msg("S", 12, 64'd0, 8'h00, 32'd0, 32'd0, 1'b1);
    wait_idle();
    chk("t3_drop", 64'(drop_cnt), 64'd1);
    chk("t3_no_err", 64'(err_seen), 64'd0);
    exp_q.push_back(mk(ITCH_ADD, 64'hAAAA_0000_0000_0042, 1'b0, 32'h0102_0304, 32'h00C0_FFEE));
    send_msg("A", 36, 64'hAAAA_0000_0000_0042, "B", 32'h0102_0304, 32'h00C0_FFEE, 1'b1);
    wait_idle();
    chk("t3_msg", 64'(msg_cnt), 64'd4);

    send_msg("E", 21, 64'd9, 8'h00, 32'd1, 32'd0, 1'b1);
    wait_idle();
    chk("t4_early_err", 64'(err_seen), 64'd1);
    chk("t4_early_drop", 64'(drop_cnt), 64'd2);
    send_msg("E", 33, 64'd9, 8'h00, 32'd1, 32'd0, 1'b1);
    wait_idle();
    chk("t4_long_err", 64'(err_seen), 64'd2);
    chk("t4_long_drop", 64'(drop_cnt), 64'd3);
    exp_q.push_back(mk(ITCH_ADD, 64'h0000_0000_5555_6666, 1'b1, 32'd7, 32'd8));
    exp_q.push_back(mk(ITCH_EXECUTE, 64'h0000_0000_0000_0101, 1'b0, 32'd300, 32'd0));
    exp_q.push_back(mk(ITCH_EXECUTE, 64'h0000_0000_0000_0202, 1'b0, 32'h00FF_0000, 32'd0));
    send_msg("F", 40, 64'h0000_0000_5555_6666, "S", 32'd7, 32'd8, 1'b1);
    send_msg("E", 31, 64'h0000_0000_0000_0101, 8'h00, 32'd300, 32'd0, 1'b1);
    send_msg("C", 36, 64'h0000_0000_0000_0202, 8'h00, 32'h00FF_0000, 32'd0, 1'b1);
    wait_idle();
    chk("t4_msg", 64'(msg_cnt), 64'd7);
    send_msg("A", 1, 64'd0, 8'h00, 32'd0, 32'd0, 1'b1);
    send_msg("Z", 1, 64'd0, 8'h00, 32'd0, 32'd0, 1'b1);
    wait_idle();
    chk("t4_type_last_err", 64'(err_seen), 64'd3);
    chk("t4_type_last_drop", 64'(drop_cnt), 64'd5);

    out_r = 1'b0;
    exp_q.push_back(mk(ITCH_ADD, 64'h0000_0000_0BAD_F00D, 1'b1, 32'd50, 32'd60));
    send_msg("A", 36, 64'h0000_0000_0BAD_F00D, "S", 32'd50, 32'd60, 1'b1);
    n = 0;
    while (!out_v && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t5_out_v", {63'd0, out_v}, 64'd1);
    snap = out_d;
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      stable &= out_v && !in_r && out_d === snap;
    end
    chk("t5_stall_stable", {63'd0, stable}, 64'd1);
    chk("t5_msg_hold", 64'(msg_cnt), 64'd7);
    out_r = 1'b1;
    wait_idle();
    chk("t5_msg", 64'(msg_cnt), 64'd8);

    send_msg("A", 15, 64'h0000_0000_0000_9999, "S", 32'd1, 32'd2, 1'b0);
    rstn = 1'b0;
    #1;
    chk("t6_rst_out_v", {63'd0, out_v}, 64'd0);
    chk("t6_rst_msg", 64'(msg_cnt), 64'd0);
    chk("t6_rst_drop", 64'(drop_cnt), 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back(mk(ITCH_DELETE, 64'h0000_0000_0000_4321, 1'b0, 32'd0, 32'd0));
    send_msg("D", 19, 64'h0000_0000_0000_4321, 8'h00, 32'd0, 32'd0, 1'b1);
    wait_idle();
    chk("t6_msg", 64'(msg_cnt), 64'd1);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
